// File: rtl/clock_pkg.sv
// Shared constants and helpers for the BCD time keeper.
// Holds the BCD digit width, per-field digit limits and wrap targets, and
// the elaboration-time conversion of the binary reset hour into display form.
package clock_pkg;

    localparam int unsigned DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t tens;
        bcd_t units;
    } bcd_pair_t;

    // Seconds and minutes both run 00..59
    localparam bcd_t SM_LIMIT_T = 4'd5;
    localparam bcd_t SM_LIMIT_U = 4'd9;

    // 24-hour clock: 00..23, wraps to 00
    localparam bcd_t H24_LIMIT_T = 4'd2;
    localparam bcd_t H24_LIMIT_U = 4'd3;
    localparam bcd_pair_t H24_WRAP = '{tens: 4'd0, units: 4'd0};

    // 12-hour clock: 12 is the top of the cycle, wraps to 01
    localparam bcd_t H12_LIMIT_T = 4'd1;
    localparam bcd_t H12_LIMIT_U = 4'd2;
    localparam bcd_pair_t H12_WRAP = '{tens: 4'd0, units: 4'd1};

    // Binary hour (0..23) to the BCD pair shown on the display
    function automatic bcd_pair_t reset_hours_bcd(int unsigned hours, bit mode12);
        int unsigned h;
        bcd_pair_t   r;
        h = hours % 24;
        if (mode12) begin
            h = h % 12;
            if (h == 0) h = 12;
        end
        r.tens  = bcd_t'(h / 10);
        r.units = bcd_t'(h % 10);
        return r;
    endfunction

    function automatic logic reset_pm(int unsigned hours, bit mode12);
        return mode12 && ((hours % 24) >= 12);
    endfunction

endpackage

// File: rtl/bcd_pair_counter.sv
// Two-digit BCD counter with programmable top value and wrap target.
// Ports:
//   clk, reset        - clock and synchronous active-high reset
//   reset_value       - pair loaded on reset
//   inc               - advance by one (wraps to wrap_value at the limit)
//   clr               - force 00 (takes priority over inc)
//   limit_t, limit_u  - last value before wrapping
//   wrap_value        - value taken after the limit
//   tens, units       - registered digits
//   carry_out         - combinational: inc while sitting at the limit
module bcd_pair_counter
    import clock_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  bcd_pair_t reset_value,
    input  logic      inc,
    input  logic      clr,
    input  bcd_t      limit_t,
    input  bcd_t      limit_u,
    input  bcd_pair_t wrap_value,
    output bcd_t      tens,
    output bcd_t      units,
    output logic      carry_out
);

    logic at_limit;

    assign at_limit  = (tens == limit_t) && (units == limit_u);
    assign carry_out = inc && at_limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            tens  <= reset_value.tens;
            units <= reset_value.units;
        end else if (clr) begin
            tens  <= '0;
            units <= '0;
        end else if (inc) begin
            if (at_limit) begin
                tens  <= wrap_value.tens;
                units <= wrap_value.units;
            end else if (units == 4'd9) begin
                units <= '0;
                tens  <= tens + 4'd1;
            end else begin
                units <= units + 4'd1;
            end
        end
    end

    // Digits must stay in 0..9
    assert property (@(posedge clk) disable iff (reset) (tens <= 4'd9) && (units <= 4'd9));

endmodule

// File: rtl/bcd_time_keeper.sv
// HH:MM:SS time keeper with packed BCD digits for the digit renderer.
// Ports:
//   clk, reset          - clock and synchronous active-high reset
//   tick_en             - 1 Hz strobe, advances seconds when no adjust is active
//   adj_hours           - increment hours (no effect on minutes/seconds)
//   adj_minutes         - increment minutes, never carries into hours
//   adj_seconds         - clear seconds
//   sec_u..hr_t         - registered BCD digits
//   pm                  - afternoon flag in 12-hour mode, 0 otherwise
//   sec_wrap            - one-cycle strobe after a tick-driven 59->00 rollover
module bcd_time_keeper
    import clock_pkg::*;
#(
    parameter bit          HOUR_MODE_12 = 1'b0,
    parameter int unsigned RESET_HOURS  = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic       adj_hours,
    input  logic       adj_minutes,
    input  logic       adj_seconds,
    output logic [3:0] sec_u,
    output logic [3:0] sec_t,
    output logic [3:0] min_u,
    output logic [3:0] min_t,
    output logic [3:0] hr_u,
    output logic [3:0] hr_t,
    output logic       pm,
    output logic       sec_wrap
);

    localparam bcd_pair_t HR_RESET   = reset_hours_bcd(RESET_HOURS, HOUR_MODE_12);
    localparam logic      PM_RESET   = reset_pm(RESET_HOURS, HOUR_MODE_12);
    localparam bcd_t      HR_LIMIT_T = HOUR_MODE_12 ? H12_LIMIT_T : H24_LIMIT_T;
    localparam bcd_t      HR_LIMIT_U = HOUR_MODE_12 ? H12_LIMIT_U : H24_LIMIT_U;
    localparam bcd_pair_t HR_WRAP    = HOUR_MODE_12 ? H12_WRAP : H24_WRAP;

    logic set_mode;
    logic tick_run;
    logic sec_carry;
    logic min_inc;
    logic min_carry_raw;
    logic min_carry;
    logic hr_inc;
    logic hr_carry;
    logic pm_toggle;

    // Any adjust pulse drops the tick for this cycle, so no carry can race it
    assign set_mode  = adj_hours | adj_minutes | adj_seconds;
    assign tick_run  = tick_en & ~set_mode;
    assign min_inc   = adj_minutes | sec_carry;
    // Only a tick-driven minute rollover carries into hours
    assign min_carry = min_carry_raw & ~set_mode;
    assign hr_inc    = adj_hours | min_carry;
    assign pm_toggle = HOUR_MODE_12 && hr_inc && (hr_t == 4'd1) && (hr_u == 4'd1);

    bcd_pair_counter u_sec (
        .clk         (clk),
        .reset       (reset),
        .reset_value ('0),
        .inc         (tick_run),
        .clr         (adj_seconds),
        .limit_t     (SM_LIMIT_T),
        .limit_u     (SM_LIMIT_U),
        .wrap_value  ('0),
        .tens        (sec_t),
        .units       (sec_u),
        .carry_out   (sec_carry)
    );

    bcd_pair_counter u_min (
        .clk         (clk),
        .reset       (reset),
        .reset_value ('0),
        .inc         (min_inc),
        .clr         (1'b0),
        .limit_t     (SM_LIMIT_T),
        .limit_u     (SM_LIMIT_U),
        .wrap_value  ('0),
        .tens        (min_t),
        .units       (min_u),
        .carry_out   (min_carry_raw)
    );

    bcd_pair_counter u_hr (
        .clk         (clk),
        .reset       (reset),
        .reset_value (HR_RESET),
        .inc         (hr_inc),
        .clr         (1'b0),
        .limit_t     (HR_LIMIT_T),
        .limit_u     (HR_LIMIT_U),
        .wrap_value  (HR_WRAP),
        .tens        (hr_t),
        .units       (hr_u),
        .carry_out   (hr_carry)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            pm       <= PM_RESET;
            sec_wrap <= 1'b0;
        end else begin
            if (pm_toggle) pm <= ~pm;
            sec_wrap <= sec_carry;
        end
    end

    // The 12->01 wrap and the 11->12 pm toggle are distinct hour values
    assert property (@(posedge clk) disable iff (reset) !(hr_carry && pm_toggle));

endmodule

// File: doc/bcd_time_keeper.md
Name: bcd_time_keeper

Overview:
- Consumer end of the button auto-repeat pulse interface: takes one-cycle adjust pulses (hours/minutes/seconds-clear) and a 1 Hz tick strobe.
- Maintains HH:MM:SS as six packed BCD digits for the VGA digit renderer.
- Sits between the button pulse generators and the display logic; the only owner of time state.

Parameters:
- HOUR_MODE_12, 0, 0 = 24-hour (00..23); 1 = 12-hour (12,01..11) with pm flag.
- RESET_HOURS, 0, hours value loaded on reset as binary 0..23. In 12h mode it is converted to 12h form + pm.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_en  in  1  one-cycle strobe, once per second.
- adj_hours  in  1  one-cycle pulse: increment hours.
- adj_minutes  in  1  one-cycle pulse: increment minutes.
- adj_seconds  in  1  one-cycle pulse: clear seconds to 00.
- sec_u  out  4  seconds units BCD.
- sec_t  out  4  seconds tens BCD (0..5).
- min_u  out  4  minutes units BCD.
- min_t  out  4  minutes tens BCD (0..5).
- hr_u  out  4  hours units BCD.
- hr_t  out  4  hours tens BCD (0..2).
- pm  out  1  12h mode only: afternoon flag. Tied 0 in 24h mode.
- sec_wrap  out  1  registered strobe, high one cycle after a tick-driven 59->00 seconds rollover.

Behaviour:
- All outputs registered; updates visible the cycle after the causing input.
- Reset values:
  - seconds 00, minutes 00, sec_wrap 0.
  - 24h mode: hours = RESET_HOURS.
  - 12h mode: RESET_HOURS 0 -> 12 with pm 0; RESET_HOURS 13 -> 01 with pm 1.
- Reset overrides all inputs in the same cycle.
- Run mode (no adjust pulse asserted):
  - tick_en increments seconds.
  - Seconds 59 -> 00 carries to minutes; minutes 59 -> 00 carries to hours.
  - 24h hours: 23 -> 00.
  - 12h hours: 12 -> 01, and 11 -> 12 toggles pm.
  - Full chain in one cycle: 23:59:59 + tick -> 00:00:00.
- Set mode (any adj_* asserted in a cycle):
  - tick_en in that cycle is dropped entirely. It is not deferred, so no carry can race an adjustment.
  - adj_hours: hours +1 with the same wrap as run mode, including the 12h pm toggle on 11 -> 12. Minutes and seconds untouched.
  - adj_minutes: minutes +1, 59 -> 00 with NO carry into hours.
  - adj_seconds: seconds forced to 00.
  - Multiple adj_* in the same cycle: each applies to its own field independently.
- sec_wrap:
  - Asserts only on a tick-driven seconds rollover, never on adj_seconds.
  - Deasserts the following cycle.
- BCD arithmetic:
  - Units digit 9 -> 0 with a carry into tens.
  - Digits never hold a non-BCD value. The invariant is checked in simulation; no recovery logic is required.
- Input pulses longer than one cycle are treated as repeated pulses, one increment per high cycle. The upstream generator guarantees single-cycle pulses.
- tick_en may coincide with reset; reset wins.

Decomposition:
- Shared package (clock_pkg), holding:
  - BCD digit width constant (4).
  - Seconds/minutes limit constants (5,9).
  - 24h hour limit constants (2,3).
  - 12h hour constants (1,2 and wrap-to 01).
- One sub-module, bcd_pair_counter:
  - Two-digit BCD counter with inputs inc, clr, limit_t, limit_u, wrap_value.
  - Outputs the two digits plus a combinational carry_out (high when inc and at limit).
  - Instantiated for seconds and minutes.
  - Hours also use it, with wrap_value selected per HOUR_MODE_12; the pm toggle stays in the top level.

Test Plan:
- Reset, 24h, RESET_HOURS=0 -> all digits 0, pm 0, sec_wrap 0. Then 60 ticks -> 00:01:00, with sec_wrap high exactly once, one cycle after the 60th tick.
- Preload 23:59:59 via adjust pulses (23 adj_hours, 59 adj_minutes; then 59 ticks) -> one more tick yields 00:00:00 and sec_wrap pulse.
- Minutes at 59, adj_minutes -> minutes 00, hours unchanged. 24 adj_hours from 00 -> back to 00.
- tick_en and adj_minutes in the same cycle with time 00:00:10 -> 00:01:10 (tick dropped). adj_seconds alone -> seconds 00, sec_wrap stays 0.
- HOUR_MODE_12=1, reset -> 12:00:00 pm 0. adj_hours -> 01. Ten more -> 11. Next -> 12 pm 1. Tick rollover from 11:59:59 pm 1 -> 12:00:00 pm 0.
- Reset asserted mid-count at 14:37:22 together with tick_en and adj_hours -> next cycle shows RESET_HOURS:00:00, no sec_wrap.
